// File: rtl/tx_frame_sequencer_if.sv
// Frame request, payload byte handshake and serial bit output bundle
// for the transmit framing controller.
interface tx_frame_sequencer_if #(
  parameter int unsigned LEN_WIDTH = 7
);
  logic                 i_start;
  logic [LEN_WIDTH-1:0] i_length;
  logic                 i_bit_en;
  logic [7:0]           i_byte;
  logic                 i_byte_valid;
  logic                 o_byte_req;
  logic                 o_bit_data;
  logic                 o_bit_valid;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_underrun;

  // Controlling side: issues frame requests, supplies bytes and strobes.
  modport master (
    output i_start, i_length, i_bit_en, i_byte, i_byte_valid,
    input  o_byte_req, o_bit_data, o_bit_valid, o_busy, o_done, o_underrun
  );

  // Sequencer side.
  modport slave (
    input  i_start, i_length, i_bit_en, i_byte, i_byte_valid,
    output o_byte_req, o_bit_data, o_bit_valid, o_busy, o_done, o_underrun
  );
endinterface

// File: rtl/tx_frame_sequencer.sv
// IEEE 802.15.4 O-QPSK PPDU serializer: preamble, SFD, PHR and PSDU
// sent LSB-first, one bit per rate-generator slot. PSDU bytes are
// prefetched into a one-byte holding register over a valid/ready link.
module tx_frame_sequencer #(
  parameter int unsigned PREAMBLE_BYTES = 4,
  parameter logic [7:0]  SFD_VALUE      = 8'hA7,
  parameter int unsigned LEN_WIDTH      = 7
) (
  input logic              i_clk,
  input logic              i_rst_n,
  tx_frame_sequencer_if.slave bus
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] PRE_LAST = LEN_WIDTH'(PREAMBLE_BYTES - 1);
  localparam int unsigned          PHR_PAD  = 8 - LEN_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PHR      = 3'd3,
    ST_PAYLOAD  = 3'd4
  } state_t;

  state_t               state_r;
  logic [7:0]           shift_r;
  logic [2:0]           bit_cnt_r;
  logic [LEN_WIDTH-1:0] byte_cnt_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [7:0]           hold_r;
  logic                 hold_full_r;
  logic [LEN_WIDTH-1:0] fetched_r;
  // Set at an octet boundary in PAYLOAD: the next slot must pull a new
  // octet from the holding register (or declare underrun).
  logic                 need_r;
  logic                 byte_req_r;
  logic                 bit_data_r;
  logic                 bit_valid_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 underrun_r;

  logic                 xfer_s;
  logic                 load_s;
  logic                 hold_full_nxt_s;
  logic [LEN_WIDTH-1:0] fetched_nxt_s;
  logic                 req_nxt_s;
  logic [LEN_WIDTH-1:0] cnt_inc_s;

  // Holding-register bookkeeping; byte_req is derived from next-cycle occupancy so it never depends on i_byte_valid.
  always_comb begin
    xfer_s          = byte_req_r & bus.i_byte_valid;
    load_s          = (state_r == ST_PAYLOAD) & bus.i_bit_en & need_r & hold_full_r;
    hold_full_nxt_s = xfer_s | (hold_full_r & ~load_s);
    fetched_nxt_s   = fetched_r + (xfer_s ? LEN_ONE : LEN_ZERO);
    req_nxt_s       = ~hold_full_nxt_s & (fetched_nxt_s < len_r);
    cnt_inc_s       = byte_cnt_r + LEN_ONE;
  end

  // Frame sequencing FSM with prefetch and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      byte_cnt_r  <= LEN_ZERO;
      len_r       <= LEN_ZERO;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      fetched_r   <= LEN_ZERO;
      need_r      <= 1'b0;
      byte_req_r  <= 1'b0;
      bit_data_r  <= 1'b0;
      bit_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      bit_valid_r <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
      hold_full_r <= hold_full_nxt_s;
      fetched_r   <= fetched_nxt_s;
      byte_req_r  <= req_nxt_s;
      if (xfer_s) begin
        hold_r <= bus.i_byte;
      end else begin
        hold_r <= hold_r;
      end

      case (state_r)
        ST_IDLE: begin
          byte_req_r <= 1'b0;
          busy_r     <= 1'b0;
          // busy_r still high here means the done/underrun cycle; wait one more.
          if (bus.i_start && !busy_r) begin
            len_r       <= bus.i_length;
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= LEN_ZERO;
            fetched_r   <= LEN_ZERO;
            hold_full_r <= 1'b0;
            need_r      <= 1'b0;
            busy_r      <= 1'b1;
            byte_req_r  <= (bus.i_length != LEN_ZERO);
            state_r     <= ST_PREAMBLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_PREAMBLE, ST_SFD, ST_PHR: begin
          if (bus.i_bit_en) begin
            bit_data_r  <= shift_r[0];
            bit_valid_r <= 1'b1;
            shift_r     <= {1'b0, shift_r[7:1]};
            bit_cnt_r   <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              if (state_r == ST_PREAMBLE) begin
                if (byte_cnt_r == PRE_LAST) begin
                  byte_cnt_r <= LEN_ZERO;
                  shift_r    <= SFD_VALUE;
                  state_r    <= ST_SFD;
                end else begin
                  byte_cnt_r <= cnt_inc_s;
                end
              end else if (state_r == ST_SFD) begin
                shift_r <= {{PHR_PAD{1'b0}}, len_r};
                state_r <= ST_PHR;
              end else if (len_r == LEN_ZERO) begin
                done_r     <= 1'b1;
                byte_req_r <= 1'b0;
                state_r    <= ST_IDLE;
              end else begin
                byte_cnt_r <= LEN_ZERO;
                need_r     <= 1'b1;
                state_r    <= ST_PAYLOAD;
              end
            end else begin
              state_r <= state_r;
            end
          end else begin
            state_r <= state_r;
          end
        end

        ST_PAYLOAD: begin
          if (bus.i_bit_en) begin
            if (need_r) begin
              if (hold_full_r) begin
                // First bit of a new octet comes straight from the holding register.
                bit_data_r  <= hold_r[0];
                bit_valid_r <= 1'b1;
                shift_r     <= {1'b0, hold_r[7:1]};
                bit_cnt_r   <= 3'd1;
                need_r      <= 1'b0;
              end else begin
                underrun_r <= 1'b1;
                byte_req_r <= 1'b0;
                need_r     <= 1'b0;
                state_r    <= ST_IDLE;
              end
            end else begin
              bit_data_r  <= shift_r[0];
              bit_valid_r <= 1'b1;
              shift_r     <= {1'b0, shift_r[7:1]};
              bit_cnt_r   <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                if (cnt_inc_s == len_r) begin
                  done_r     <= 1'b1;
                  byte_req_r <= 1'b0;
                  state_r    <= ST_IDLE;
                end else begin
                  byte_cnt_r <= cnt_inc_s;
                  need_r     <= 1'b1;
                end
              end else begin
                state_r <= ST_PAYLOAD;
              end
            end
          end else begin
            state_r <= ST_PAYLOAD;
          end
        end

        default: begin
          byte_req_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_byte_req  = byte_req_r;
  assign bus.o_bit_data  = bit_data_r;
  assign bus.o_bit_valid = bit_valid_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_done      = done_r;
  assign bus.o_underrun  = underrun_r;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer: expected frame bits are
// queued when a frame is launched and popped as the DUT emits them.
module tb_tx_frame_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tx_frame_sequencer_if #(.LEN_WIDTH(7)) bus();

  tx_frame_sequencer #(
    .PREAMBLE_BYTES(4),
    .SFD_VALUE(8'hA7),
    .LEN_WIDTH(7)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  bit         exp_q[$];
  logic [7:0] pay [0:127];

  int   n_bits, n_hs, n_done, n_uf, spacing_bad, stray, done_alone, uf_with_bit, leftover;
  logic busy_start, busy_end_cycle, busy_after;
  bit   timed_out;

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  // Launch one frame, drive strobe/source, pop-compare every emitted bit.
  task automatic run_frame(input int len, input int avail, input int period,
                           input int pct, input int mid_start, input int budget);
    int         idx, lowcnt, last_c;
    logic       en, vld, hs, fin;
    logic [7:0] lb;
    bit         exp_bit;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_byte(8'h00);
    push_byte(8'hA7);
    lb = 8'(len);
    push_byte(lb);
    for (int i = 0; i < len && i < avail; i++) push_byte(pay[i]);
    n_bits = 0; n_hs = 0; n_done = 0; n_uf = 0; spacing_bad = 0; stray = 0;
    done_alone = 0; uf_with_bit = 0; busy_end_cycle = 1'b0; busy_after = 1'b1;
    bus.i_bit_en = 1'b0; bus.i_byte_valid = 1'b0;
    bus.i_length = 7'(len); bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    busy_start = bus.o_busy;
    idx = 0; lowcnt = 0; last_c = -1; fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      en = ((c % period) == 0);
      if (idx < avail) begin
        if (pct >= 100) vld = 1'b1;
        else begin
          vld = (lowcnt >= 3) || ($urandom_range(0, 99) < pct);
          lowcnt = vld ? 0 : lowcnt + 1;
        end
      end else vld = 1'b0;
      bus.i_bit_en     = en;
      bus.i_byte_valid = vld;
      bus.i_byte       = (idx < 128) ? pay[idx] : 8'h00;
      bus.i_start      = (c == mid_start);
      bus.i_length     = (c == mid_start) ? 7'd5 : 7'(len);
      hs = bus.o_byte_req && vld;
      @(posedge clk); #1;
      if (hs) begin idx++; n_hs++; end
      if (bus.o_bit_valid) begin
        n_bits++;
        if (!en) stray++;
        if (last_c >= 0 && (c - last_c) != period) spacing_bad++;
        last_c = c;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_bit: bit %0d emitted, none expected", n_bits);
        end else begin
          exp_bit = exp_q.pop_front();
          if (bus.o_bit_data !== exp_bit) begin
            tests_failed++;
            $display("FAIL bit_data[%0d]: got %b want %b", n_bits - 1, bus.o_bit_data, exp_bit);
          end
        end
      end
      if (bus.o_done) begin
        n_done++;
        if (!bus.o_bit_valid || exp_q.size() != 0) done_alone++;
      end
      if (bus.o_underrun) begin
        n_uf++;
        if (bus.o_bit_valid) uf_with_bit++;
      end
      if (bus.o_done || bus.o_underrun) begin
        busy_end_cycle = bus.o_busy;
        fin = 1'b1;
      end
    end
    bus.i_bit_en = 1'b0; bus.i_byte_valid = 1'b0; bus.i_start = 1'b0;
    timed_out = !fin;
    if (fin) begin
      @(posedge clk); #1;
      busy_after = bus.o_busy;
    end
    leftover = exp_q.size();
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.i_length = 7'd0; bus.i_bit_en = 1'b0;
    bus.i_byte = 8'h00; bus.i_byte_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (bus.o_busy !== 1'b0)      begin tests_failed++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    tests_run++; if (bus.o_bit_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_bit_valid: got %b want 0", bus.o_bit_valid); end
    tests_run++; if (bus.o_bit_data !== 1'b0)  begin tests_failed++; $display("FAIL rst_bit_data: got %b want 0", bus.o_bit_data); end
    tests_run++; if (bus.o_byte_req !== 1'b0)  begin tests_failed++; $display("FAIL rst_byte_req: got %b want 0", bus.o_byte_req); end
    tests_run++; if (bus.o_done !== 1'b0)      begin tests_failed++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
    tests_run++; if (bus.o_underrun !== 1'b0)  begin tests_failed++; $display("FAIL rst_underrun: got %b want 0", bus.o_underrun); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len0();
    run_frame(0, 0, 1, 100, -1, 100);
    tests_run++; if (busy_start !== 1'b1)    begin tests_failed++; $display("FAIL len0_busy_start: got %b want 1", busy_start); end
    tests_run++; if (timed_out !== 1'b0)     begin tests_failed++; $display("FAIL len0_timeout: got %b want 0", timed_out); end
    tests_run++; if (n_bits !== 48)          begin tests_failed++; $display("FAIL len0_bits: got %0d want 48", n_bits); end
    tests_run++; if (n_hs !== 0)             begin tests_failed++; $display("FAIL len0_handshakes: got %0d want 0", n_hs); end
    tests_run++; if (n_done !== 1)           begin tests_failed++; $display("FAIL len0_done: got %0d want 1", n_done); end
    tests_run++; if (done_alone !== 0)       begin tests_failed++; $display("FAIL len0_done_with_last: got %0d want 0", done_alone); end
    tests_run++; if (busy_end_cycle !== 1'b1) begin tests_failed++; $display("FAIL len0_busy_done_cycle: got %b want 1", busy_end_cycle); end
    tests_run++; if (busy_after !== 1'b0)    begin tests_failed++; $display("FAIL len0_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_len2();
    pay[0] = 8'h5A; pay[1] = 8'h3C;
    run_frame(2, 2, 1, 100, -1, 120);
    tests_run++; if (n_bits !== 64)    begin tests_failed++; $display("FAIL len2_bits: got %0d want 64", n_bits); end
    tests_run++; if (n_hs !== 2)       begin tests_failed++; $display("FAIL len2_handshakes: got %0d want 2", n_hs); end
    tests_run++; if (n_done !== 1)     begin tests_failed++; $display("FAIL len2_done: got %0d want 1", n_done); end
    tests_run++; if (leftover !== 0)   begin tests_failed++; $display("FAIL len2_leftover: got %0d want 0", leftover); end
    tests_run++; if (n_uf !== 0)       begin tests_failed++; $display("FAIL len2_underrun: got %0d want 0", n_uf); end
  endtask

  task automatic test_slow_strobe();
    pay[0] = 8'hE1;
    run_frame(1, 1, 4, 100, -1, 300);
    tests_run++; if (n_bits !== 56)      begin tests_failed++; $display("FAIL slow_bits: got %0d want 56", n_bits); end
    tests_run++; if (spacing_bad !== 0)  begin tests_failed++; $display("FAIL slow_spacing: got %0d bad gaps want 0", spacing_bad); end
    tests_run++; if (stray !== 0)        begin tests_failed++; $display("FAIL slow_stray_valid: got %0d want 0", stray); end
    tests_run++; if (n_done !== 1)       begin tests_failed++; $display("FAIL slow_done: got %0d want 1", n_done); end
    tests_run++; if (done_alone !== 0)   begin tests_failed++; $display("FAIL slow_done_with_last: got %0d want 0", done_alone); end
  endtask

  task automatic test_underrun();
    pay[0] = 8'h96; pay[1] = 8'h00; pay[2] = 8'h00;
    run_frame(3, 1, 1, 100, -1, 120);
    tests_run++; if (n_bits !== 56)        begin tests_failed++; $display("FAIL uf_bits: got %0d want 56", n_bits); end
    tests_run++; if (n_uf !== 1)           begin tests_failed++; $display("FAIL uf_pulse: got %0d want 1", n_uf); end
    tests_run++; if (n_done !== 0)         begin tests_failed++; $display("FAIL uf_no_done: got %0d want 0", n_done); end
    tests_run++; if (uf_with_bit !== 0)    begin tests_failed++; $display("FAIL uf_no_bit: got %0d want 0", uf_with_bit); end
    tests_run++; if (busy_after !== 1'b0)  begin tests_failed++; $display("FAIL uf_busy_after: got %b want 0", busy_after); end
    run_frame(0, 0, 1, 100, -1, 100);
    tests_run++; if (n_bits !== 48)        begin tests_failed++; $display("FAIL uf_restart_bits: got %0d want 48", n_bits); end
    tests_run++; if (n_done !== 1)         begin tests_failed++; $display("FAIL uf_restart_done: got %0d want 1", n_done); end
  endtask

  task automatic test_mid_start_and_reset();
    pay[0] = 8'hC3;
    run_frame(1, 1, 1, 100, 20, 120);
    tests_run++; if (n_bits !== 56)   begin tests_failed++; $display("FAIL midstart_bits: got %0d want 56", n_bits); end
    tests_run++; if (n_done !== 1)    begin tests_failed++; $display("FAIL midstart_done: got %0d want 1", n_done); end
    tests_run++; if (leftover !== 0)  begin tests_failed++; $display("FAIL midstart_leftover: got %0d want 0", leftover); end
    // Start a length-2 frame and drive it into PAYLOAD, then reset mid-cycle.
    bus.i_length = 7'd2; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_bit_en = 1'b1; bus.i_byte_valid = 1'b1; bus.i_byte = 8'h11;
    repeat (52) @(posedge clk);
    #1;
    tests_run++; if (bus.o_busy !== 1'b1) begin tests_failed++; $display("FAIL prerst_busy: got %b want 1", bus.o_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_bit_valid, bus.o_bit_data, bus.o_byte_req, bus.o_done, bus.o_underrun} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %b want 000000",
               {bus.o_busy, bus.o_bit_valid, bus.o_bit_data, bus.o_byte_req, bus.o_done, bus.o_underrun});
    end
    bus.i_bit_en = 1'b0; bus.i_byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pay[0] = 8'hA5; pay[1] = 8'h0F;
    run_frame(2, 2, 1, 100, -1, 120);
    tests_run++; if (n_bits !== 64)   begin tests_failed++; $display("FAIL postrst_bits: got %0d want 64", n_bits); end
    tests_run++; if (n_done !== 1)    begin tests_failed++; $display("FAIL postrst_done: got %0d want 1", n_done); end
    tests_run++; if (n_hs !== 2)      begin tests_failed++; $display("FAIL postrst_handshakes: got %0d want 2", n_hs); end
  endtask

  task automatic test_len127();
    for (int i = 0; i < 128; i++) pay[i] = 8'($urandom_range(0, 255));
    run_frame(127, 127, 1, 50, -1, 1300);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL l127_timeout: got %b want 0", timed_out); end
    tests_run++; if (n_bits !== 1064)    begin tests_failed++; $display("FAIL l127_bits: got %0d want 1064", n_bits); end
    tests_run++; if (n_hs !== 127)       begin tests_failed++; $display("FAIL l127_handshakes: got %0d want 127", n_hs); end
    tests_run++; if (n_uf !== 0)         begin tests_failed++; $display("FAIL l127_underrun: got %0d want 0", n_uf); end
    tests_run++; if (n_done !== 1)       begin tests_failed++; $display("FAIL l127_done: got %0d want 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len2();
    test_slow_strobe();
    test_underrun();
    test_mid_start_and_reset();
    test_len127();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
